// File: rtl/dmux_dispatch.sv
// Dispatcher feeding the 1-to-4 demux: buffers {dest, data} beats in a small FIFO
// and issues one registered beat per cycle unless the head's channel is busy.
module dmux_dispatch #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  input  logic [1:0]               in_dest,
  input  logic                     rr_mode,
  input  logic [3:0]               chan_busy,
  output logic [W-1:0]             out_data,
  output logic [1:0]               out_sel,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = W + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    rr_q, rr_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [1:0]    out_sel_q, out_sel_d;
  logic          out_valid_q, out_valid_d;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] head_s;
  logic [1:0]    dest_s;

  // Handshake, pop decision and next-state computation.
  always_comb begin
    full_s      = (level_q == LW'(DEPTH));
    empty_s     = (level_q == {LW{1'b0}});
    in_ready    = !rst && !full_s;
    push_s      = in_valid && in_ready;
    head_s      = mem_q[rd_ptr_q];
    pop_s       = !empty_s && !chan_busy[head_s[EW-1:W]];

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rr_d        = rr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = 1'b0;

    // Round-robin pointer only moves on beats accepted in round-robin mode.
    if (rr_mode) begin
      dest_s = rr_q;
    end else begin
      dest_s = in_dest;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (rr_mode) begin
        rr_d = rr_q + 2'd1;
      end else begin
        rr_d = rr_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_data_d  = head_s[W-1:0];
      out_sel_d   = head_s[EW-1:W];
      out_valid_d = 1'b1;
    end else begin
      rd_ptr_d    = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state and registered demux outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {LW{1'b0}};
      rr_q        <= 2'd0;
      out_data_q  <= {W{1'b0}};
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rr_q        <= rr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  // FIFO storage; push is already blocked during reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {dest_s, in_data};
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;

endmodule

// File: tb/tb_dmux_dispatch.sv
// Directed self-checking bench for dmux_dispatch.
module tb_dmux_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_dest;
  logic       rr_mode;
  logic [3:0] chan_busy;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;

  dmux_dispatch #(.W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode),
    .chan_busy(chan_busy), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk({tag, "_data"},  {4'd0, out_data},  {4'd0, d});
    chk({tag, "_sel"},   {6'd0, out_sel},   {6'd0, s});
  endtask

  initial begin
    logic [1:0] exp_sel;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'h9; in_dest = 2'd1;
    rr_mode = 1'b0; chan_busy = 4'h0;

    // reset held two cycles with in_valid high
    tick(); tick();
    chk("rst_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_data",  {4'd0, out_data}, 8'd0);
    chk("rst_sel",   {6'd0, out_sel}, 8'd0);
    chk("rst_level", {5'd0, level}, 8'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_ready", {7'd0, in_ready}, 8'd1);

    // addressed stream
    in_valid = 1'b1; in_data = 4'hA; in_dest = 2'd0;
    tick();
    chk("addr_lvl1", {5'd0, level}, 8'd1);
    chk("addr_nov", {7'd0, out_valid}, 8'd0);
    in_data = 4'h5; in_dest = 2'd3;
    tick();
    chk_beat("addr_b0", 4'hA, 2'd0);
    in_data = 4'hC; in_dest = 2'd1;
    tick();
    chk_beat("addr_b1", 4'h5, 2'd3);
    in_data = 4'hF; in_dest = 2'd2;
    tick();
    chk_beat("addr_b2", 4'hC, 2'd1);
    chk("addr_lvl_steady", {5'd0, level}, 8'd1);
    in_valid = 1'b0;
    tick();
    chk_beat("addr_b3", 4'hF, 2'd2);
    chk("addr_lvl0", {5'd0, level}, 8'd0);
    tick();
    chk("addr_idle_valid", {7'd0, out_valid}, 8'd0);
    chk("addr_idle_data", {4'd0, out_data}, 8'h0F);
    chk("addr_idle_sel", {6'd0, out_sel}, 8'd2);

    // round-robin wrap, in_dest ignored
    rr_mode = 1'b1; in_dest = 2'd3; in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_data = 4'(i);
      tick();
      if (i >= 2) begin
        exp_sel = 2'(i - 2);
        chk_beat("rr", 4'(i - 1), exp_sel);
      end
    end
    in_valid = 1'b0;
    tick();
    chk_beat("rr_last", 4'd6, 2'd1);
    tick();
    chk("rr_idle", {7'd0, out_valid}, 8'd0);

    // full / backpressure
    rr_mode = 1'b0; in_dest = 2'd0; chan_busy = 4'hF; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 4'(i);
      tick();
    end
    chk("full_lvl", {5'd0, level}, 8'd4);
    chk("full_ready", {7'd0, in_ready}, 8'd0);
    in_data = 4'd5;
    tick();
    chk("full_lvl_hold", {5'd0, level}, 8'd4);
    chk("full_nov", {7'd0, out_valid}, 8'd0);
    chan_busy = 4'h0;
    tick();
    chk_beat("bp_b1", 4'd1, 2'd0);
    chk("bp_lvl3", {5'd0, level}, 8'd3);
    chk("bp_ready", {7'd0, in_ready}, 8'd1);
    tick();
    chk_beat("bp_b2", 4'd2, 2'd0);
    chk("bp_lvl3b", {5'd0, level}, 8'd3);
    in_valid = 1'b0;
    tick();
    chk_beat("bp_b3", 4'd3, 2'd0);
    tick();
    chk_beat("bp_b4", 4'd4, 2'd0);
    tick();
    chk_beat("bp_b5", 4'd5, 2'd0);
    chk("bp_lvl0", {5'd0, level}, 8'd0);

    // head-of-line block
    in_valid = 1'b1; in_data = 4'h7; in_dest = 2'd2;
    tick();
    chk("hol_post5_nov", {7'd0, out_valid}, 8'd0);
    chan_busy = 4'b0100; in_data = 4'h8; in_dest = 2'd0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("hol_stall_valid", {7'd0, out_valid}, 8'd0);
      chk("hol_stall_data", {4'd0, out_data}, 8'h05);
      chk("hol_stall_sel", {6'd0, out_sel}, 8'd0);
      if (c < 2) tick();
    end
    chk("hol_lvl2", {5'd0, level}, 8'd2);
    chan_busy = 4'h0;
    tick();
    chk_beat("hol_b0", 4'h7, 2'd2);
    tick();
    chk_beat("hol_b1", 4'h8, 2'd0);
    tick();
    chk("hol_idle", {7'd0, out_valid}, 8'd0);

    // reset mid-operation: rr pointer is at 2 here
    chan_busy = 4'hF; in_dest = 2'd1; in_valid = 1'b1;
    in_data = 4'h9; tick();
    in_data = 4'hA; tick();
    in_data = 4'hB; tick();
    chk("mid_lvl3", {5'd0, level}, 8'd3);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    chk("mid_rst_lvl", {5'd0, level}, 8'd0);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_data", {4'd0, out_data}, 8'd0);
    chk("mid_rst_ready", {7'd0, in_ready}, 8'd0);
    rst = 1'b0; chan_busy = 4'h0; rr_mode = 1'b1; in_valid = 1'b1; in_data = 4'hD;
    #1;
    chk("mid_ready", {7'd0, in_ready}, 8'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk_beat("mid_rr", 4'hD, 2'd0);
    chk("mid_lvl0", {5'd0, level}, 8'd0);
    tick();
    chk("mid_no_stale", {7'd0, out_valid}, 8'd0);
    tick();
    chk("mid_no_stale2", {7'd0, out_valid}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
